lf_sub_pipe: RTL

LF_SUB_PIPE -- requirements
Module: lf_sub_pipe

---
 rtl/lf_pkg.sv | 21 ++
 rtl/lf_prefix_level.sv | 23 ++
 rtl/lf_sub_pipe.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/lf_pkg.sv
// Shared types and helpers for the Ladner-Fischer pipelined subtractor.
package lf_pkg;

  typedef struct packed {
    logic g;
    logic p;
  } pg_t;

  localparam int unsigned LF_SUB_STAGES = 3;

  // Ceiling log2, evaluated at elaboration time.
  function automatic int unsigned lf_log2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/lf_prefix_level.sv
// One Ladner-Fischer prefix level: the upper half of each 2^(LEVEL+1) block merges with
// the most significant bit of the lower half.
module lf_prefix_level
  import lf_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LEVEL = 0
) (
  input  pg_t [WIDTH-1:0] pg_prev,
  output pg_t [WIDTH-1:0] pg_next
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (((i >> LEVEL) % 2) == 1) begin : g_merge
      localparam int unsigned J = ((i >> LEVEL) << LEVEL) - 1;
      assign pg_next[i].g = pg_prev[i].g | (pg_prev[i].p & pg_prev[J].g);
      assign pg_next[i].p = pg_prev[i].p & pg_prev[J].p;
    end else begin : g_pass
      assign pg_next[i] = pg_prev[i];
    end
  end

endmodule

// File: rtl/lf_sub_pipe.sv
// Three-stage elastic subtractor (a - b) built on a Ladner-Fischer prefix tree.
// Define LF_SUB_OVF_EN to add the pipelined signed-overflow output ovf.
module lf_sub_pipe
  import lf_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef LF_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned Levels = lf_log2(WIDTH);

  // Handshake and stage valid bits
  logic s1_valid_q, s2_valid_q, s3_valid_q;
  logic s1_adv, s2_adv, s3_adv, in_acc;

  always_comb begin
    s3_adv   = s3_valid_q & out_ready;
    s2_adv   = s2_valid_q & (~s3_valid_q | s3_adv);
    s1_adv   = s1_valid_q & (~s2_valid_q | s2_adv);
    in_ready = ~s1_valid_q | s1_adv;
    in_acc   = in_valid & in_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
    end else begin
      if (in_ready) s1_valid_q <= in_valid;
      if (!s2_valid_q || s2_adv) s2_valid_q <= s1_valid_q;
      if (!s3_valid_q || s3_adv) s3_valid_q <= s2_valid_q;
    end
  end

  // Stage 1: bitwise generate/propagate of a + ~b, carry-in of 1 folded into bit 0
  logic [WIDTH-1:0] nb, s1_x_d;
  pg_t  [WIDTH-1:0] s1_pg_d;

  always_comb begin
    nb     = ~b;
    s1_x_d = a ^ nb;
    for (int i = 0; i < WIDTH; i++) begin
      s1_pg_d[i].g = a[i] & nb[i];
      s1_pg_d[i].p = s1_x_d[i];
    end
    s1_pg_d[0].g = a[0] | nb[0];
  end

  pg_t  [WIDTH-1:0] s1_pg_q;
  logic [WIDTH-1:0] s1_x_q;
`ifdef LF_SUB_OVF_EN
  logic s1_am_q, s1_bm_q;
`endif

  always_ff @(posedge clk) begin
    if (in_acc) begin
      s1_pg_q <= s1_pg_d;
      s1_x_q  <= s1_x_d;
`ifdef LF_SUB_OVF_EN
      s1_am_q <= a[WIDTH-1];
      s1_bm_q <= b[WIDTH-1];
`endif
    end
  end

  // Stage 2: prefix levels 0 .. Levels-2
  for (genvar k = 0; k < Levels - 1; k++) begin : g_s2
    pg_t [WIDTH-1:0] pg_lvl;
    if (k == 0) begin : g_first
      lf_prefix_level #(
        .WIDTH(WIDTH),
        .LEVEL(k)
      ) u_lvl (
        .pg_prev(s1_pg_q),
        .pg_next(pg_lvl)
      );
    end else begin : g_chain
      lf_prefix_level #(
        .WIDTH(WIDTH),
        .LEVEL(k)
      ) u_lvl (
        .pg_prev(g_s2[k-1].pg_lvl),
        .pg_next(pg_lvl)
      );
    end
  end

  pg_t  [WIDTH-1:0] s2_pg_d, s2_pg_q;
  logic [WIDTH-1:0] s2_x_q;
`ifdef LF_SUB_OVF_EN
  logic s2_am_q, s2_bm_q;
`endif

  assign s2_pg_d = g_s2[Levels-2].pg_lvl;

  always_ff @(posedge clk) begin
    if (s1_adv) begin
      s2_pg_q <= s2_pg_d;
      s2_x_q  <= s1_x_q;
`ifdef LF_SUB_OVF_EN
      s2_am_q <= s1_am_q;
      s2_bm_q <= s1_bm_q;
`endif
    end
  end

  // Stage 3: final prefix level, sum and borrow
  pg_t  [WIDTH-1:0] s3_pg;
  logic [WIDTH-1:0] grp_g, grp_p, carry, s3_diff_d;
  logic             s3_borrow_d;

  lf_prefix_level #(
    .WIDTH(WIDTH),
    .LEVEL(Levels - 1)
  ) u_last (
    .pg_prev(s2_pg_q),
    .pg_next(s3_pg)
  );

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      grp_g[i] = s3_pg[i].g;
      grp_p[i] = s3_pg[i].p;
    end
    carry       = {grp_g[WIDTH-2:0], 1'b1};
    s3_diff_d   = s2_x_q ^ carry;
    s3_borrow_d = ~grp_g[WIDTH-1];
  end

  // Group propagates out of the last level have no consumer.
  logic unused_grp_p;
  assign unused_grp_p = ^grp_p;

  logic [WIDTH-1:0] s3_diff_q;
  logic             s3_borrow_q;
`ifdef LF_SUB_OVF_EN
  logic s3_ovf_d, s3_ovf_q;
  assign s3_ovf_d = (s2_am_q != s2_bm_q) && (s3_diff_d[WIDTH-1] != s2_am_q);
`endif

  always_ff @(posedge clk) begin
    if (s2_adv) begin
      s3_diff_q   <= s3_diff_d;
      s3_borrow_q <= s3_borrow_d;
`ifdef LF_SUB_OVF_EN
      s3_ovf_q    <= s3_ovf_d;
`endif
    end
  end

  assign out_valid = s3_valid_q;
  assign diff      = s3_diff_q;
  assign borrow    = s3_borrow_q;
`ifdef LF_SUB_OVF_EN
  assign ovf       = s3_ovf_q;
`endif

endmodule
